// File: rtl/aes_decryp_iter.sv
// AES-128 iterative inverse cipher: ten forward key-schedule steps reach K10,
// then one decryption round per clock while the schedule is walked backwards.
module aes_decryp_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iValid,
  output logic         oReady,
  input  logic [127:0] iKey,
  input  logic [127:0] iCiphertext,
  output logic         oValid,
  output logic [127:0] oPlaintext
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2
  } fsm_e;

  fsm_e         fsm_r, fsmNext_s;
  logic [3:0]   rnd_r;
  logic [127:0] key_r, blk_r;
  logic         rndOk_s;
  logic [31:0]  a0_s, a1_s, a2_s, a3_s, b3_s, subIn_s, subOut_s, fwd0_s;
  logic [7:0]   rcon_s;
  logic [127:0] fwdKey_s, bwdKey_s, invSb_s, addKey_s, invMc_s;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = {aa[6:0], 1'b0} ^ (8'h1b & {8{aa[7]}});
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] sq, acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gfInv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] y);
    logic [7:0] u;
    u = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gfInv(u);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rconOf(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] w);
    logic [7:0] c0, c1, c2, c3;
    c0 = w[31:24];
    c1 = w[23:16];
    c2 = w[15:8];
    c3 = w[7:0];
    return {gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09),
            gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d),
            gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b),
            gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e)};
  endfunction

  assign rndOk_s = (rnd_r >= 4'd1) && (rnd_r <= 4'd10);

  // Key schedule: the single SubWord path serves forward and backward steps
  always_comb begin
    a0_s   = key_r[127:96];
    a1_s   = key_r[95:64];
    a2_s   = key_r[63:32];
    a3_s   = key_r[31:0];
    b3_s   = a3_s ^ a2_s;
    rcon_s = rconOf(rnd_r);
    if (fsm_r == ROUND) begin
      subIn_s = b3_s;
    end else begin
      subIn_s = a3_s;
    end
    subOut_s = subWord({subIn_s[23:0], subIn_s[31:24]});
    fwd0_s   = a0_s ^ subOut_s ^ {rcon_s, 24'h000000};
    fwdKey_s = {fwd0_s, a1_s ^ fwd0_s, a2_s ^ a1_s ^ fwd0_s, a3_s ^ a2_s ^ a1_s ^ fwd0_s};
    bwdKey_s = {fwd0_s, a1_s ^ a0_s, a2_s ^ a1_s, b3_s};
  end

  // Round datapath: InvShiftRows folded into the inverse S-box indexing
  always_comb begin
    invSb_s = 128'h0;
    invMc_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        invSb_s[127 - 8 * (4 * c + r) -: 8] =
          invSbox(blk_r[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
      end
    end
    addKey_s = invSb_s ^ bwdKey_s;
    for (int c = 0; c < 4; c++) begin
      invMc_s[127 - 32 * c -: 32] = invMixCol(addKey_s[127 - 32 * c -: 32]);
    end
  end

  // Next-state logic; any out-of-range round count falls back to IDLE
  always_comb begin
    fsmNext_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (iValid && oReady) fsmNext_s = KEYEXP;
        else                  fsmNext_s = IDLE;
      end
      KEYEXP: begin
        if (!rndOk_s)             fsmNext_s = IDLE;
        else if (rnd_r == 4'd10)  fsmNext_s = ROUND;
        else                      fsmNext_s = KEYEXP;
      end
      ROUND: begin
        if (!rndOk_s || rnd_r == 4'd1) fsmNext_s = IDLE;
        else                           fsmNext_s = ROUND;
      end
      default: fsmNext_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_r <= IDLE;
    else        fsm_r <= fsmNext_s;
  end

  // Key, block, round counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r      <= 128'h0;
      blk_r      <= 128'h0;
      rnd_r      <= 4'd0;
      oValid     <= 1'b0;
      oReady     <= 1'b1;
      oPlaintext <= 128'h0;
    end else begin
      oValid <= 1'b0;
      oReady <= (fsmNext_s == IDLE);
      case (fsm_r)
        IDLE: begin
          if (iValid && oReady) begin
            key_r <= iKey;
            blk_r <= iCiphertext;
            rnd_r <= 4'd1;
          end
        end
        KEYEXP: begin
          if (rndOk_s) begin
            key_r <= fwdKey_s;
            if (rnd_r == 4'd10) blk_r <= blk_r ^ fwdKey_s;
            else                rnd_r <= rnd_r + 4'd1;
          end
        end
        ROUND: begin
          if (rndOk_s) begin
            key_r <= bwdKey_s;
            rnd_r <= rnd_r - 4'd1;
            if (rnd_r == 4'd1) begin
              oPlaintext <= addKey_s;
              oValid     <= 1'b1;
            end else begin
              blk_r <= invMc_s;
            end
          end
        end
        default: rnd_r <= 4'd0;
      endcase
    end
  end

endmodule
